// File: rtl/lacc_mem_bridge.sv
// lacc_mem_bridge: buffers accelerator memory requests, issues them on the
// split request/response memory bus with a bounded number in flight, and
// returns read data in order. Write responses are absorbed here; a flush
// drops queued requests and silences every read still in flight.
module lacc_mem_bridge #(
    parameter int REQ_DEPTH   = 4,
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lacc_flush,
    input  logic        lacc_data_valid,
    output logic        lacc_data_ready,
    input  logic [31:0] lacc_data_addr,
    input  logic        lacc_data_read,
    input  logic [31:0] lacc_data_wdata,
    input  logic [1:0]  lacc_data_size,
    output logic        lacc_drsp_valid,
    output logic [31:0] lacc_drsp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    localparam int RPW = $clog2(REQ_DEPTH);
    localparam int RCW = $clog2(REQ_DEPTH) + 1;
    localparam int TPW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int TCW = $clog2(OUTSTANDING) + 1;

    // Request FIFO storage
    logic [31:0]    fifoAddr_q  [REQ_DEPTH];
    logic           fifoRead_q  [REQ_DEPTH];
    logic [31:0]    fifoWdata_q [REQ_DEPTH];
    logic [1:0]     fifoSize_q  [REQ_DEPTH];
    logic [RPW-1:0] wrPtr_q, wrPtr_d;
    logic [RPW-1:0] rdPtr_q, rdPtr_d;
    logic [RCW-1:0] count_q, count_d;

    // Tag FIFO: one read/write bit per issued memory transaction
    logic           tagRead_q [OUTSTANDING];
    logic [TPW-1:0] tagWrPtr_q, tagWrPtr_d;
    logic [TPW-1:0] tagRdPtr_q, tagRdPtr_d;
    logic [TCW-1:0] inflight_q, inflight_d;
    logic [TCW-1:0] readCount_q, readCount_d;
    logic [TCW-1:0] discard_q, discard_d;

    logic           drspValid_q, drspValid_d;
    logic [31:0]    drspRdata_q, drspRdata_d;

    logic           reqFull;
    logic           reqEmpty;
    logic           enq;
    logic           issue;
    logic           rspPop;
    logic           popIsRead;
    logic           headRead;
    logic [31:0]    headAddr;
    logic [31:0]    headWdata;
    logic [1:0]     headSize;
    logic [1:0]     headOff;

    assign reqFull         = (count_q == RCW'(REQ_DEPTH));
    assign reqEmpty        = (count_q == '0);
    assign lacc_data_ready = ~reqFull & ~lacc_flush;
    assign enq             = lacc_data_valid & lacc_data_ready;

    assign headAddr  = fifoAddr_q[rdPtr_q];
    assign headRead  = fifoRead_q[rdPtr_q];
    assign headWdata = fifoWdata_q[rdPtr_q];
    assign headSize  = fifoSize_q[rdPtr_q];
    assign headOff   = headAddr[1:0];

    assign mem_req_valid = ~reqEmpty & (inflight_q < TCW'(OUTSTANDING)) & ~lacc_flush;
    assign mem_req_addr  = {headAddr[31:2], 2'b00};
    assign mem_req_we    = ~headRead;
    assign issue         = mem_req_valid & mem_req_ready;

    // Responses with nothing in flight are protocol violations and are dropped
    assign rspPop    = mem_rsp_valid & (inflight_q != '0);
    assign popIsRead = tagRead_q[tagRdPtr_q];

    assign lacc_drsp_valid = drspValid_q;
    assign lacc_drsp_rdata = drspRdata_q;

    // Place the head entry's write data and strobes into their byte lanes
    always_comb begin
        mem_req_wstrb = 4'b1111;
        mem_req_wdata = headWdata;
        case (headSize)
            2'd0: begin
                mem_req_wstrb = 4'b0001 << headOff;
                mem_req_wdata = {24'h0, headWdata[7:0]} << {headOff, 3'b000};
            end
            2'd1: begin
                mem_req_wstrb = 4'b0011 << {headOff[1], 1'b0};
                mem_req_wdata = {16'h0, headWdata[15:0]} << {headOff[1], 4'b0000};
            end
            default: begin
                mem_req_wstrb = 4'b1111;
                mem_req_wdata = headWdata;
            end
        endcase
        if (headRead) begin
            mem_req_wstrb = 4'b0000;
        end
    end

    // Next-state for FIFO pointers, in-flight tracking, discard and response
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        tagWrPtr_d  = tagWrPtr_q;
        tagRdPtr_d  = tagRdPtr_q;
        inflight_d  = inflight_q;
        readCount_d = readCount_q;
        discard_d   = discard_q;
        drspValid_d = 1'b0;
        drspRdata_d = drspRdata_q;

        if (lacc_flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wrPtr_d = wrPtr_q + RPW'(1);
            end
            if (issue) begin
                rdPtr_d = rdPtr_q + RPW'(1);
            end
            case ({enq, issue})
                2'b10:   count_d = count_q + RCW'(1);
                2'b01:   count_d = count_q - RCW'(1);
                default: count_d = count_q;
            endcase
        end

        if (issue) begin
            tagWrPtr_d = (tagWrPtr_q == TPW'(OUTSTANDING - 1)) ? '0 : tagWrPtr_q + TPW'(1);
        end
        if (rspPop) begin
            tagRdPtr_d = (tagRdPtr_q == TPW'(OUTSTANDING - 1)) ? '0 : tagRdPtr_q + TPW'(1);
        end

        case ({issue, rspPop})
            2'b10:   inflight_d = inflight_q + TCW'(1);
            2'b01:   inflight_d = inflight_q - TCW'(1);
            default: inflight_d = inflight_q;
        endcase

        readCount_d = readCount_q + TCW'(issue & headRead) - TCW'(rspPop & popIsRead);

        // Every read still in flight after this cycle's response gets silenced
        if (lacc_flush) begin
            discard_d = readCount_q - TCW'(rspPop & popIsRead);
        end else if (rspPop & popIsRead & (discard_q != '0)) begin
            discard_d = discard_q - TCW'(1);
        end

        if (rspPop & popIsRead & (discard_q == '0) & ~lacc_flush) begin
            drspValid_d = 1'b1;
            drspRdata_d = mem_rsp_rdata;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            tagWrPtr_q  <= '0;
            tagRdPtr_q  <= '0;
            inflight_q  <= '0;
            readCount_q <= '0;
            discard_q   <= '0;
            drspValid_q <= 1'b0;
            drspRdata_q <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            tagWrPtr_q  <= tagWrPtr_d;
            tagRdPtr_q  <= tagRdPtr_d;
            inflight_q  <= inflight_d;
            readCount_q <= readCount_d;
            discard_q   <= discard_d;
            drspValid_q <= drspValid_d;
            drspRdata_q <= drspRdata_d;
        end
    end

    // Payload storage; validity is tracked by the counters, so no reset needed
    always_ff @(posedge clk) begin
        if (enq) begin
            fifoAddr_q[wrPtr_q]  <= lacc_data_addr;
            fifoRead_q[wrPtr_q]  <= lacc_data_read;
            fifoWdata_q[wrPtr_q] <= lacc_data_wdata;
            fifoSize_q[wrPtr_q]  <= lacc_data_size;
        end
        if (issue) begin
            tagRead_q[tagWrPtr_q] <= headRead;
        end
    end

endmodule

// File: tb/tb_lacc_mem_bridge.sv
// tb_lacc_mem_bridge: directed test-plan scenarios followed by randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_lacc_mem_bridge;

    localparam int REQ_DEPTH   = 4;
    localparam int OUTSTANDING = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lacc_flush;
    logic        lacc_data_valid;
    logic        lacc_data_ready;
    logic [31:0] lacc_data_addr;
    logic        lacc_data_read;
    logic [31:0] lacc_data_wdata;
    logic [1:0]  lacc_data_size;
    logic        lacc_drsp_valid;
    logic [31:0] lacc_drsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    lacc_mem_bridge #(.REQ_DEPTH(REQ_DEPTH), .OUTSTANDING(OUTSTANDING)) dut (
        .clk             (clk),
        .rst             (rst),
        .lacc_flush      (lacc_flush),
        .lacc_data_valid (lacc_data_valid),
        .lacc_data_ready (lacc_data_ready),
        .lacc_data_addr  (lacc_data_addr),
        .lacc_data_read  (lacc_data_read),
        .lacc_data_wdata (lacc_data_wdata),
        .lacc_data_size  (lacc_data_size),
        .lacc_drsp_valid (lacc_drsp_valid),
        .lacc_drsp_rdata (lacc_drsp_rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_we      (mem_req_we),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wstrb   (mem_req_wstrb),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_rdata   (mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [1:0]  size;
    } accReq_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memReq_t;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        dropped;
        int          due;
    } pend_t;

    accReq_t     offerQ[$];
    memReq_t     reqQ[$];
    pend_t       pendQ[$];

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          readyPct = 100;
    int          rspJitter = 0;
    bit          rspHold = 0;
    bit          seqData = 0;
    logic [31:0] seqVal = 32'h0;
    bit          flushReq = 0;
    bit          expDrsp = 0;
    logic [31:0] expDrspData = 32'h0;
    int          accCount = 0;
    int          issueCount = 0;
    int          drspCount = 0;
    logic [31:0] lastAddr = 32'h0;
    logic [31:0] lastWdata = 32'h0;
    logic [3:0]  lastWstrb = 4'h0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, obs, exp);
        end
    endtask

    // Expected memory request from the byte-lane rules, computed lane by lane
    function automatic memReq_t toMem(accReq_t r);
        memReq_t m;
        int off;
        int nbytes;
        int lane;
        off    = int'(r.addr[1:0]);
        nbytes = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        lane   = (nbytes == 4) ? 0 : (off / nbytes) * nbytes;
        m.addr  = r.addr & 32'hFFFF_FFFC;
        m.we    = ~r.rd;
        m.wstrb = 4'h0;
        m.wdata = 32'h0;
        if (!r.rd) begin
            for (int b = 0; b < nbytes; b++) begin
                m.wstrb[lane + b]          = 1'b1;
                m.wdata[8*(lane + b) +: 8] = r.wdata[8*b +: 8];
            end
        end
        return m;
    endfunction

    task automatic offer(input logic [31:0] addr, input logic rd, input logic [31:0] wdata, input logic [1:0] size);
        accReq_t r;
        r.addr  = addr;
        r.rd    = rd;
        r.wdata = wdata;
        r.size  = size;
        offerQ.push_back(r);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, update model
    task automatic applyStimulus();
        bit      acc;
        bit      iss;
        bit      expReady;
        bit      expValid;
        pend_t   p;
        memReq_t m;

        lacc_flush = flushReq;
        flushReq   = 0;
        if (offerQ.size() > 0) begin
            lacc_data_valid = 1'b1;
            lacc_data_addr  = offerQ[0].addr;
            lacc_data_read  = offerQ[0].rd;
            lacc_data_wdata = offerQ[0].wdata;
            lacc_data_size  = offerQ[0].size;
        end else begin
            lacc_data_valid = 1'b0;
            lacc_data_addr  = $urandom;
            lacc_data_read  = 1'($urandom);
            lacc_data_wdata = $urandom;
            lacc_data_size  = 2'($urandom);
        end
        mem_req_ready = ($urandom_range(99) < readyPct);
        if (!rspHold && pendQ.size() > 0 && pendQ[0].due <= cycle) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = pendQ[0].data;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
        end

        @(negedge clk);
        expReady = (reqQ.size() < REQ_DEPTH) && !lacc_flush;
        expValid = (reqQ.size() > 0) && (pendQ.size() < OUTSTANDING) && !lacc_flush;
        checkOutput("data_ready", 64'(lacc_data_ready), 64'(expReady));
        checkOutput("req_valid", 64'(mem_req_valid), 64'(expValid));
        checkOutput("drsp_valid", 64'(lacc_drsp_valid), 64'(expDrsp));
        if (expDrsp && lacc_drsp_valid) begin
            checkOutput("drsp_rdata", 64'(lacc_drsp_rdata), 64'(expDrspData));
        end
        if (lacc_drsp_valid) drspCount++;
        if (expValid && mem_req_valid) begin
            m = reqQ[0];
            checkOutput("req_addr", 64'(mem_req_addr), 64'(m.addr));
            checkOutput("req_we", 64'(mem_req_we), 64'(m.we));
            checkOutput("req_wstrb", 64'(mem_req_wstrb), 64'(m.wstrb));
            if (m.we) checkOutput("req_wdata", 64'(mem_req_wdata), 64'(m.wdata));
        end

        acc = lacc_data_valid && lacc_data_ready;
        iss = mem_req_valid && mem_req_ready;

        expDrsp = 0;
        if (mem_rsp_valid) begin
            p = pendQ.pop_front();
            if (p.rd && !p.dropped && !lacc_flush) begin
                expDrsp     = 1;
                expDrspData = p.data;
            end
        end
        if (lacc_flush) begin
            foreach (pendQ[i]) pendQ[i].dropped = 1'b1;
            reqQ.delete();
        end
        if (iss && reqQ.size() > 0) begin
            m = reqQ.pop_front();
            lastAddr  = mem_req_addr;
            lastWdata = mem_req_wdata;
            lastWstrb = mem_req_wstrb;
            p.rd      = ~m.we;
            p.data    = seqData ? seqVal : $urandom;
            if (seqData) seqVal = seqVal + 32'h1;
            p.dropped = 1'b0;
            p.due     = cycle + 1 + $urandom_range(rspJitter);
            pendQ.push_back(p);
            issueCount++;
        end
        if (acc && offerQ.size() > 0) begin
            reqQ.push_back(toMem(offerQ[0]));
            void'(offerQ.pop_front());
            accCount++;
        end

        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    // Reset (optionally together with flush) and check the reset state
    task automatic doReset(input bit withFlush);
        rst             = 1'b1;
        lacc_flush      = withFlush;
        lacc_data_valid = 1'b0;
        mem_req_ready   = 1'b0;
        mem_rsp_valid   = 1'b0;
        @(posedge clk);
        #1;
        lacc_flush = 1'b0;
        @(negedge clk);
        checkOutput("rst_data_ready", 64'(lacc_data_ready), 64'h1);
        checkOutput("rst_req_valid", 64'(mem_req_valid), 64'h0);
        checkOutput("rst_drsp_valid", 64'(lacc_drsp_valid), 64'h0);
        checkOutput("rst_drsp_rdata", 64'(lacc_drsp_rdata), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        offerQ.delete();
        reqQ.delete();
        pendQ.delete();
        expDrsp = 0;
    endtask

    initial begin
        rst             = 1'b1;
        lacc_flush      = 1'b0;
        lacc_data_valid = 1'b0;
        lacc_data_addr  = 32'h0;
        lacc_data_read  = 1'b0;
        lacc_data_wdata = 32'h0;
        lacc_data_size  = 2'd0;
        mem_req_ready   = 1'b0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_rdata   = 32'h0;
        doReset(1'b0);

        $display("[TB] word read burst");
        seqData = 1;
        seqVal  = 32'hA0;
        drspCount = 0;
        for (int i = 0; i < 4; i++) offer(32'h100 + 32'(4 * i), 1'b1, 32'h0, 2'd2);
        runCycles(12);
        checkOutput("burst_pulses", 64'(drspCount), 64'd4);
        checkOutput("burst_last_addr", 64'(lastAddr), 64'h10C);
        seqData = 0;

        $display("[TB] sub-word writes");
        drspCount = 0;
        offer(32'h203, 1'b0, 32'hDEAD_BE5A, 2'd0);
        runCycles(5);
        checkOutput("byte_wstrb", 64'(lastWstrb), 64'h8);
        checkOutput("byte_wdata", 64'(lastWdata), 64'h5A00_0000);
        offer(32'h202, 1'b0, 32'hCAFE_1234, 2'd1);
        runCycles(5);
        checkOutput("half_wstrb", 64'(lastWstrb), 64'hC);
        checkOutput("half_wdata", 64'(lastWdata), 64'h1234_0000);
        checkOutput("write_pulses", 64'(drspCount), 64'd0);

        $display("[TB] backpressure");
        readyPct = 0;
        accCount = 0;
        issueCount = 0;
        drspCount = 0;
        for (int i = 0; i < 6; i++) offer(32'h300 + 32'(4 * i), 1'b1, 32'h0, 2'd2);
        runCycles(10);
        checkOutput("bp_accepted", 64'(accCount), 64'd4);
        checkOutput("bp_ready_low", 64'(lacc_data_ready), 64'h0);
        readyPct = 100;
        runCycles(15);
        checkOutput("bp_issued", 64'(issueCount), 64'd6);
        checkOutput("bp_pulses", 64'(drspCount), 64'd6);

        $display("[TB] outstanding limit");
        rspHold = 1;
        issueCount = 0;
        for (int i = 0; i < 5; i++) offer(32'h400 + 32'(4 * i), 1'b1, 32'h0, 2'd2);
        runCycles(10);
        checkOutput("os_issued", 64'(issueCount), 64'd4);
        rspHold = 0;
        runCycles(1);
        checkOutput("os_issued_rsp", 64'(issueCount), 64'd4);
        runCycles(1);
        checkOutput("os_issued_next", 64'(issueCount), 64'd5);
        runCycles(10);

        $display("[TB] flush with in-flight reads");
        rspHold = 1;
        issueCount = 0;
        drspCount = 0;
        for (int i = 0; i < 3; i++) offer(32'h500 + 32'(4 * i), 1'b1, 32'h0, 2'd2);
        runCycles(5);
        readyPct = 0;
        offer(32'h600, 1'b1, 32'h0, 2'd2);
        offer(32'h604, 1'b1, 32'h0, 2'd2);
        runCycles(4);
        flushReq = 1;
        runCycles(1);
        rspHold = 0;
        readyPct = 100;
        offer(32'h700, 1'b1, 32'h0, 2'd2);
        runCycles(15);
        checkOutput("flush_issued", 64'(issueCount), 64'd4);
        checkOutput("flush_pulses", 64'(drspCount), 64'd1);

        $display("[TB] mixed order");
        drspCount = 0;
        offer(32'h800, 1'b1, 32'h0, 2'd2);
        offer(32'h804, 1'b0, 32'h1111_2222, 2'd2);
        offer(32'h808, 1'b1, 32'h0, 2'd2);
        offer(32'h80D, 1'b0, 32'h0000_0077, 2'd0);
        runCycles(12);
        checkOutput("mixed_pulses", 64'(drspCount), 64'd2);

        $display("[TB] randomized traffic");
        rspJitter = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) readyPct = $urandom_range(30, 100);
            if (i == 1500) doReset(1'b1);
            if (offerQ.size() < 3 && $urandom_range(99) < 60) begin
                offer($urandom & 32'hFFFF, 1'($urandom), $urandom, 2'($urandom));
            end
            if ($urandom_range(99) < 3) flushReq = 1;
            applyStimulus();
        end
        readyPct = 100;
        runCycles(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
